// File: rtl/alu_exec_pkg.sv
// Shared definitions for the execute-stage ALU: op codes, shift amount width, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_exec_pkg;

  localparam int SHAMT_W = 5;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } alu_state_e;

  // Shifts are the only ops that may take more than one cycle.
  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL);
  endfunction

endpackage

// File: rtl/alu_iter_shifter.sv
// Iterative logical shifter: moves at most SHIFT_STEP bit positions per cycle.
// Latency: ceil(shamt/SHIFT_STEP) cycles after load; done flags the final step's cycle.
// Backpressure: none; the owner only loads it when idle and takes data_out when done.
module alu_iter_shifter
  import alu_exec_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               load,
  input  logic               dir,      // 0: left (sll), 1: right logical (srl)
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [DATA_W-1:0]  data_in,
  output logic               done,
  output logic [DATA_W-1:0]  data_out
);

  localparam logic [SHAMT_W-1:0] STEP = SHAMT_W'(SHIFT_STEP);

  logic [DATA_W-1:0]  shreg;
  logic [SHAMT_W-1:0] cnt;
  logic [SHAMT_W-1:0] k;
  logic               dir_q;

  // One step: shift by min(STEP, remaining); done when this step empties the counter.
  always_comb begin
    k        = (cnt > STEP) ? STEP : cnt;
    data_out = dir_q ? (shreg >> k) : (shreg << k);
    done     = (cnt != '0) && (cnt <= STEP);
  end

  // Shift register and remaining-count; flush abandons the shift in progress.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg <= '0;
      cnt   <= '0;
      dir_q <= 1'b0;
    end else if (flush) begin
      cnt <= '0;
    end else if (load) begin
      shreg <= data_in;
      cnt   <= shamt;
      dir_q <= dir;
    end else if (cnt != '0) begin
      shreg <= data_out;
      cnt   <= cnt - k;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU with registered result and zero flag; valid/ready on both sides.
// Latency: 1 cycle for logic/add/sub/sltu and zero shifts, 1+ceil(shamt/SHIFT_STEP) for shifts.
// Backpressure: result held until out_ready; in_ready drops while shifting or output is stalled.
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        control_signal,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  alu_state_e         state, state_nxt;
  logic               accept;
  logic               shift_start;
  logic               sh_done;
  logic [SHAMT_W-1:0] shamt;
  logic [DATA_W-1:0]  alu_res;
  logic [DATA_W-1:0]  sh_data;

  assign shamt       = op_b[SHAMT_W-1:0];
  assign in_ready    = (state == ST_IDLE) && (!out_valid || out_ready) && !flush;
  assign accept      = in_valid && in_ready;
  assign shift_start = accept && is_shift_op(control_signal) && (shamt != '0);

  // Single-cycle datapath; a shift reaching here has shamt==0 so it passes op_a through.
  always_comb begin
    alu_res = '0;
    case (control_signal)
      ALU_AND:          alu_res = op_a & op_b;
      ALU_OR:           alu_res = op_a | op_b;
      ALU_ADD:          alu_res = op_a + op_b;
      ALU_SUB:          alu_res = op_a - op_b;
      ALU_SLTU:         alu_res = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
      ALU_SLL, ALU_SRL: alu_res = op_a;
      default:          alu_res = '0;
    endcase
  end

  alu_iter_shifter #(
    .DATA_W     (DATA_W),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .load     (shift_start),
    .dir      (control_signal == ALU_SRL),
    .shamt    (shamt),
    .data_in  (op_a),
    .done     (sh_done),
    .data_out (sh_data)
  );

  // Next state: enter SHIFT on a real shift, leave on the final step; flush forces IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (shift_start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (sh_done)     state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Output register: load on single-cycle accept or shift completion, clear on handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept && !shift_start) begin
        result    <= alu_res;
        zero      <= (alu_res == '0);
        out_valid <= 1'b1;
      end else if ((state == ST_SHIFT) && sh_done) begin
        result    <= sh_data;
        zero      <= (sh_data == '0);
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed cases plus a randomised run under backpressure.
// Latency: n/a.
// Backpressure: out_ready driven directly or randomised each cycle.
module tb_alu_exec;
  import alu_exec_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [3:0]  control_signal;
  logic [31:0] op_a, op_b;
  logic        in_ready, out_valid, zero;
  logic [31:0] result;

  logic        in_valid4, out_ready4, flush4;
  logic        in_ready4, out_valid4, zero4;
  logic [31:0] result4;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [32:0] sb[$];
  logic        rand_bp = 1'b0;

  always #5 clk = ~clk;

  alu_exec #(.DATA_W(32), .SHIFT_STEP(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .control_signal(control_signal), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero)
  );

  alu_exec #(.DATA_W(32), .SHIFT_STEP(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush4), .in_valid(in_valid4), .in_ready(in_ready4),
    .control_signal(control_signal), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid4), .out_ready(out_ready4), .result(result4), .zero(zero4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Reference behaviour: {zero, result}.
  function automatic logic [32:0] model(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    case (c)
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      default:  r = 32'd0;
    endcase
    return {(r == 32'd0), r};
  endfunction

  // Scoreboard: push on accept, pop on output handshake; flush/reset drop everything.
  always @(negedge clk) begin
    if (!rst || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_out", {31'b0, out_valid}, 32'd0);
        end else begin
          logic [32:0] e;
          e = sb.pop_front();
          check("sb_result", result, e[31:0]);
          check("sb_zero", {31'b0, zero}, {31'b0, e[32]});
        end
      end
      if (in_valid && in_ready) sb.push_back(model(control_signal, op_a, op_b));
    end
  end

  // Random backpressure driver.
  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Call at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       output int waits);
    control_signal = c;
    op_a           = a;
    op_b           = b;
    in_valid       = 1'b1;
    waits          = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
    end
    check("issue_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Call at posedge+1 after accept; returns at the negedge where out_valid is first seen.
  task automatic wait_out(output int n);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (out_valid) begin
        n = i;
        break;
      end
    end
    check("out_wait", {31'b0, out_valid}, 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [3:0]  t_c[10];
  logic [31:0] t_a[10];
  logic [31:0] t_b[10];
  logic [3:0]  rnd_ops[9];
  logic [32:0] exp_v;
  int          w, n, lowcnt, vcnt;

  initial begin
    t_c = '{ALU_SUB, ALU_SUB, ALU_SLTU, ALU_AND, ALU_OR, ALU_SLTU, 4'hF, 4'h5, ALU_SRL, ALU_SLL};
    t_a = '{32'd5, 32'd0, 32'd1, 32'hF0F0, 32'h1, 32'hFFFF_FFFF, 32'd5, 32'd9,
            32'h8000_0000, 32'd3};
    t_b = '{32'd5, 32'd1, 32'hFFFF_FFFF, 32'h0FF0, 32'h2, 32'd1, 32'd5, 32'd9, 32'd0, 32'd0};
    rnd_ops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SLL, ALU_SRL, ALU_SUB, ALU_SLTU, 4'h5, 4'hF};

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    control_signal = 4'd0; op_a = '0; op_b = '0;
    in_valid4 = 1'b0; out_ready4 = 1'b1; flush4 = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'b0, zero}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    rst = 1'b1;
    step();

    // ADD 7+5: one cycle latency, valid for a single cycle with out_ready high.
    issue(ALU_ADD, 32'd7, 32'd5, w);
    @(negedge clk);
    check("add_valid", {31'b0, out_valid}, 32'd1);
    check("add_result", result, 32'd12);
    check("add_zero", {31'b0, zero}, 32'd0);
    step();
    @(negedge clk);
    check("add_valid_drop", {31'b0, out_valid}, 32'd0);
    step();

    // Single-cycle table.
    for (int i = 0; i < 10; i++) begin
      issue(t_c[i], t_a[i], t_b[i], w);
      @(negedge clk);
      exp_v = model(t_c[i], t_a[i], t_b[i]);
      check("tbl_lat1", {31'b0, out_valid}, 32'd1);
      check("tbl_result", result, exp_v[31:0]);
      check("tbl_zero", {31'b0, zero}, {31'b0, exp_v[32]});
      step();
    end

    // Back-to-back single-cycle ops.
    issue(ALU_ADD, 32'd1, 32'd2, w);
    issue(ALU_SUB, 32'd10, 32'd4, w);
    issue(ALU_OR, 32'h10, 32'h01, w);
    check("b2b_no_stall", w, 32'd0);

    // SLL 1 by 31, SHIFT_STEP=1.
    issue(ALU_SLL, 32'd1, 32'h3F, w);
    lowcnt = 0; n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        n = i;
        break;
      end
      if (!in_ready) lowcnt++;
    end
    check("sll31_latency", n, 32'd32);
    check("sll31_busy", lowcnt, 32'd31);
    check("sll31_result", result, 32'h8000_0000);
    step();

    // Same shift, SHIFT_STEP=4.
    control_signal = ALU_SLL; op_a = 32'd1; op_b = 32'h3F; in_valid4 = 1'b1;
    @(negedge clk);
    check("s4_in_ready", {31'b0, in_ready4}, 32'd1);
    step();
    in_valid4 = 1'b0;
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (out_valid4) begin
        n = i;
        break;
      end
    end
    check("s4_latency", n, 32'd9);
    check("s4_result", result4, 32'h8000_0000);
    step();

    // SRL by 4: zero fill, latency 1+4.
    issue(ALU_SRL, 32'h8000_0000, 32'd4, w);
    wait_out(n);
    check("srl4_latency", n, 32'd5);
    check("srl4_result", result, 32'h0800_0000);
    step();

    // Backpressure then handshake with same-edge accept.
    out_ready = 1'b0;
    issue(ALU_ADD, 32'd2, 32'd3, w);
    @(negedge clk);
    check("bp_valid", {31'b0, out_valid}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      check("bp_hold_result", result, 32'd5);
      check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    step();
    out_ready = 1'b1;
    issue(ALU_OR, 32'h1, 32'h2, w);
    check("bp_same_edge_accept", w, 32'd0);
    @(negedge clk);
    check("bp_or_valid", {31'b0, out_valid}, 32'd1);
    check("bp_or_result", result, 32'd3);
    step();

    // Flush in cycle 3 of a 20-bit shift.
    issue(ALU_SLL, 32'd1, 32'd20, w);
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    check("flush_in_ready", {31'b0, in_ready}, 32'd1);
    check("flush_valid", {31'b0, out_valid}, 32'd0);
    check("flush_result_hold", result, 32'd3);
    vcnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) vcnt++;
    end
    check("flush_no_output", vcnt, 32'd0);
    step();

    // Reset in the middle of a shift.
    issue(ALU_SLL, 32'd1, 32'd20, w);
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    check("mrst_valid", {31'b0, out_valid}, 32'd0);
    check("mrst_result", result, 32'd0);
    check("mrst_zero", {31'b0, zero}, 32'd0);
    check("mrst_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    rst = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) vcnt++;
    end
    check("mrst_no_output", vcnt, 32'd0);
    step();

    // Wrap-around add after reset gives zero flag.
    issue(ALU_ADD, 32'hFFFF_FFFF, 32'd1, w);
    @(negedge clk);
    check("wrap_result", result, 32'd0);
    check("wrap_zero", {31'b0, zero}, 32'd1);
    step();

    // Random ops under random backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [3:0]  c;
      logic [31:0] a, b;
      c = rnd_ops[$urandom_range(0, 8)];
      a = $urandom;
      b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
      issue(c, a, b, w);
    end
    rand_bp = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) break;
    end
    check("drain_sb", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
